noc_spike_arbiter: RTL and testbench

Front-end scheduler for the shared spike NoC bus. It collects one-cycle spike pulses from NUM_NODES neuron nodes and keeps a saturating pending-event count per node. It grants the single bus slot round-robin and presents one address-event (source node ID) per transfer on a valid/ready interface. It replaces the plain broadcast with fair, lossless-until-saturation serialisation of spikes onto the bus.

---
 rtl/noc_spike_arbiter_pkg.sv | 12 +
 rtl/noc_rr_arbiter.sv | 44 ++++
 rtl/noc_spike_arbiter.sv | 131 +++++++++++++
 tb/tb_noc_spike_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_spike_arbiter_pkg.sv
// Shared spike-NoC definitions: default bus geometry and the output-stage FSM encoding.
package noc_spike_arbiter_pkg;

  localparam int NOC_NUM_NODES  = 4;
  localparam int NOC_ADDR_WIDTH = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: first requesting node at or after the pointer,
// wrapping modulo NUM_NODES (NUM_NODES need not be a power of two).
module noc_rr_arbiter
  import noc_spike_arbiter_pkg::*;
#(
  parameter int NUM_NODES  = NOC_NUM_NODES,
  parameter int ADDR_WIDTH = NOC_ADDR_WIDTH
) (
  input  logic [NUM_NODES-1:0]  i_req,
  input  logic [ADDR_WIDTH-1:0] i_rr_ptr,
  output logic [ADDR_WIDTH-1:0] o_grant,
  output logic                  o_any_req
);

  logic [ADDR_WIDTH-1:0] w_grant;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_any;
  logic                  w_hit;

  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] base,
                                                     input int step);
    int sum;
    sum = int'(base) + step;
    return (sum >= NUM_NODES) ? ADDR_WIDTH'(sum - NUM_NODES) : ADDR_WIDTH'(sum);
  endfunction

  // Scan from the pointer; only the first hit is kept.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    w_hit   = 1'b0;
    for (int k = 0; k < NUM_NODES; k++) begin
      w_idx   = wrap_add(i_rr_ptr, k);
      w_hit   = i_req[w_idx] & ~w_any;
      w_grant = w_hit ? w_idx : w_grant;
      w_any   = w_any | i_req[w_idx];
    end
  end

  assign o_grant   = w_grant;
  assign o_any_req = w_any;

endmodule

// File: rtl/noc_spike_arbiter.sv
// Spike NoC front-end: per-node saturating pending counters, round-robin grant and a
// single-entry valid/ready output register carrying the source node ID.
module noc_spike_arbiter
  import noc_spike_arbiter_pkg::*;
#(
  parameter int NUM_NODES  = NOC_NUM_NODES,
  parameter int ADDR_WIDTH = NOC_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_NODES-1:0]  spike_in,
  input  logic                  bus_ready,
  output logic                  bus_valid,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [NUM_NODES-1:0]  pending_out,
  output logic [NUM_NODES-1:0]  drop_out,
  input  logic                  clr_drop
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_NODE = ADDR_WIDTH'(NUM_NODES - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt     [NUM_NODES];
  logic [CNT_WIDTH-1:0]  w_cnt_nxt [NUM_NODES];
  logic [ADDR_WIDTH-1:0] r_rr_ptr;
  logic [ADDR_WIDTH-1:0] w_rr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [ADDR_WIDTH-1:0] w_grant;
  logic [NUM_NODES-1:0]  r_drop;
  logic [NUM_NODES-1:0]  w_drop_set;
  logic [NUM_NODES-1:0]  w_req;
  logic [NUM_NODES-1:0]  w_dec;
  logic                  w_any_req;
  logic                  w_load;
  logic                  w_take;

  // Request vector comes from registered counts only, so a spike waits one edge.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      w_req[i] = (r_cnt[i] != '0);
    end
  end

  noc_rr_arbiter #(
    .NUM_NODES  (NUM_NODES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rr_arbiter (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_grant),
    .o_any_req (w_any_req)
  );

  // Output-register FSM and round-robin pointer advance.
  always_comb begin
    w_load       = (r_state == ST_EMPTY) | bus_ready;
    w_take       = w_load & w_any_req;
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_any_req ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (bus_ready) begin
          w_state_nxt = w_any_req ? ST_FULL : ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (w_take) begin
      w_rr_ptr_nxt = (w_grant == LAST_NODE) ? '0 : w_grant + 1'b1;
    end else begin
      w_rr_ptr_nxt = r_rr_ptr;
    end
  end

  // Per-node counter update; a saturated increment with a simultaneous grant is not a drop.
  always_comb begin
    w_dec      = '0;
    w_drop_set = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_dec[i]     = w_take & (w_grant == ADDR_WIDTH'(i));
      case ({spike_in[i], w_dec[i]})
        2'b10: begin
          if (r_cnt[i] == CNT_MAX) begin
            w_drop_set[i] = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
        end
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - 1'b1;
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  // State, counters, pointer, held event and sticky drop flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_rr_ptr   <= '0;
      r_bus_addr <= '0;
      r_drop     <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (w_take) begin
        r_bus_addr <= w_grant;
      end
      r_drop <= (clr_drop ? '0 : r_drop) | w_drop_set;
      for (int i = 0; i < NUM_NODES; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus_valid   = (r_state == ST_FULL);
  assign bus_addr    = r_bus_addr;
  assign pending_out = w_req;
  assign drop_out    = r_drop;

endmodule

// File: tb/tb_noc_spike_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts grants; a negedge monitor checks them.
module tb_noc_spike_arbiter;

  localparam int N    = 4;
  localparam int MAXC = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] spike_in = '0;
  logic         bus_ready = 1'b0;
  logic         clr_drop = 1'b0;
  logic         bus_valid;
  logic [1:0]   bus_addr;
  logic [N-1:0] pending_out;
  logic [N-1:0] drop_out;

  logic [2:0]   spike3 = '0;
  logic         ready3 = 1'b1;
  logic         valid3;
  logic [1:0]   addr3;
  logic [2:0]   pend3;
  logic [2:0]   drop3;

  int errors = 0;
  int checks = 0;

  int           m_cnt [N];
  int           m_ptr;
  bit           m_held;
  logic [N-1:0] m_drop;
  int           exp_q [$];
  int           got3  [$];

  always #5 clk = ~clk;

  noc_spike_arbiter #(.NUM_NODES(4), .ADDR_WIDTH(2), .CNT_WIDTH(3)) u_dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .bus_ready(bus_ready),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .pending_out(pending_out),
    .drop_out(drop_out), .clr_drop(clr_drop)
  );

  noc_spike_arbiter #(.NUM_NODES(3), .ADDR_WIDTH(2), .CNT_WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .spike_in(spike3), .bus_ready(ready3),
    .bus_valid(valid3), .bus_addr(addr3), .pending_out(pend3),
    .drop_out(drop3), .clr_drop(1'b0)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i] = (m_cnt[i] > 0);
    return p;
  endfunction

  // Reference model: rules applied at every clock edge with plain arithmetic.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0; m_held = 0; m_drop = '0;
        exp_q.delete();
      end else begin
        int g;
        bit load;
        g = -1;
        load = !m_held || bus_ready;
        if (load) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && m_cnt[(m_ptr + k) % N] > 0) g = (m_ptr + k) % N;
          end
        end
        if (clr_drop) m_drop = '0;
        for (int i = 0; i < N; i++) begin
          if (spike_in[i] && g != i) begin
            if (m_cnt[i] == MAXC) m_drop[i] = 1'b1;
            else m_cnt[i]++;
          end else if (!spike_in[i] && g == i) begin
            m_cnt[i]--;
          end
        end
        if (load) begin
          if (g >= 0) begin
            exp_q.push_back(g);
            m_held = 1;
            m_ptr = (g + 1) % N;
          end else begin
            m_held = 0;
          end
        end
      end
    end
  end

  // Monitor: compares outputs against the model and pops accepted events.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("valid", int'(bus_valid), int'(m_held));
        check("pending", int'(pending_out), int'(model_pending()));
        check("drop", int'(drop_out), int'(m_drop));
        if (bus_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", int'(bus_addr), -1);
          end else begin
            check("addr", int'(bus_addr), exp_q[0]);
            if (bus_ready) void'(exp_q.pop_front());
          end
        end
        if (valid3 && ready3) got3.push_back(int'(addr3));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [N-1:0] spk, input logic rdy, input logic clr,
                       input logic [2:0] spk3 = 3'b000);
    spike_in  = spk;
    bus_ready = rdy;
    clr_drop  = clr;
    spike3    = spk3;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int nv;
    int n;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", int'(bus_valid), 0);
    check("rst_addr", int'(bus_addr), 0);
    check("rst_pending", int'(pending_out), 0);
    check("rst_drop", int'(drop_out), 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // Single spike: visible two edges after the pulse, for one cycle.
    drive(4'b0100, 1'b1, 1'b0);
    check("t1_valid_e0", int'(bus_valid), 0);
    check("t1_pending_e0", int'(pending_out), 4);
    drive(4'b0000, 1'b1, 1'b0);
    check("t1_valid_e1", int'(bus_valid), 1);
    check("t1_addr_e1", int'(bus_addr), 2);
    drive(4'b0000, 1'b1, 1'b0);
    check("t1_valid_e2", int'(bus_valid), 0);
    check("t1_pending_e2", int'(pending_out), 0);

    // All nodes at once.
    drive(4'b1111, 1'b1, 1'b0);
    repeat (6) drive(4'b0000, 1'b1, 1'b0);

    // Backpressure with one event held.
    drive(4'b0010, 1'b0, 1'b0);
    repeat (5) drive(4'b0000, 1'b0, 1'b0);
    check("t3_valid_held", int'(bus_valid), 1);
    check("t3_addr_held", int'(bus_addr), 1);
    drive(4'b0000, 1'b1, 1'b0);
    check("t3_done", int'(bus_valid), 0);

    // Saturation of node 1 under backpressure.
    for (int p = 1; p <= 10; p++) begin
      drive(4'b0010, 1'b0, 1'b0);
      check("t4_drop1", int'(drop_out[1]), (p >= 9) ? 1 : 0);
    end
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus_valid) nv++;
      drive(4'b0000, 1'b1, 1'b0);
    end
    check("t4_event_count", nv, 8);
    drive(4'b0000, 1'b1, 1'b1);
    check("t4_clr", int'(drop_out), 0);

    // Fairness between nodes 0 and 3, plus modulo wrap on the three-node instance.
    drive(4'b1001, 1'b1, 1'b0, 3'b100);
    repeat (3) drive(4'b1001, 1'b1, 1'b0);
    drive(4'b1001, 1'b1, 1'b0, 3'b101);
    repeat (3) drive(4'b1001, 1'b1, 1'b0);
    repeat (6) drive(4'b0000, 1'b1, 1'b0);
    check("t5_wrap_count", got3.size(), 3);
    if (got3.size() == 3) begin
      check("t5_wrap_0", got3[0], 2);
      check("t5_wrap_1", got3[1], 0);
      check("t5_wrap_2", got3[2], 2);
    end

    // Reset while an event is held and counts are pending.
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    check("t6_pre_valid", int'(bus_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", int'(bus_valid), 0);
    check("t6_rst_pending", int'(pending_out), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    spike_in = '0;
    repeat (5) drive(4'b0000, 1'b1, 1'b0);
    check("t6_idle_valid", int'(bus_valid), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    n = 0;
    while ((bus_valid || exp_q.size() != 0 || pending_out != '0) && n < 200) begin
      drive(4'b0000, 1'b1, 1'b0);
      n++;
    end
    check("drain_timeout", int'(n < 200), 1);
    check("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
